sar_result_fifo: RTL and testbench

- Downstream stage of the SAR shift-register/capacitor-control block.
- Consumes the 10-bit capacitor control word `clc` and the end-of-conversion strobe `creset` that the shift register produces.
- Captures each finished conversion word and buffers it in a small synchronous FIFO.
- Presents results to the digital back end over a valid/ready handshake, with overflow flagging and a conversion counter.

---
 rtl/sar_pkg.sv | 18 +
 rtl/sar_sync_fifo.sv | 74 +++++++
 rtl/sar_result_fifo.sv | 102 ++++++++++
 tb/tb_sar_result_fifo.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared constants and types for the SAR result path.
// Result word width, default FIFO depth and pointer-width helper.
package sar_pkg;

  localparam int SAR_ADC_BITS = 10;
  localparam int SAR_DEPTH    = 4;
  localparam int SAR_CNT_BITS = 16;

  typedef logic [SAR_ADC_BITS-1:0] sar_word_t;

  // Pointer carries one wrap bit above the index bits.
  function automatic int sar_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int SAR_PTR_W = sar_ptr_w(SAR_DEPTH);

endpackage

// File: rtl/sar_sync_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers.
// Head of queue is registered onto o_dout / o_valid.
module sar_sync_fifo
  import sar_pkg::*;
#(
  parameter int W     = SAR_ADC_BITS,
  parameter int DEPTH = SAR_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_valid,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = sar_ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [W-1:0]  r_dout;
  logic          r_valid;

  logic [PW-1:0] w_wr_n;
  logic [PW-1:0] w_rd_n;
  logic          w_push;
  logic          w_pop;
  logic          w_bypass;
  logic [W-1:0]  w_head_n;

  assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_empty = (r_wr == r_rd);

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);
  assign w_wr_n = r_wr + PW'(w_push);
  assign w_rd_n = r_rd + PW'(w_pop);

  // The word being written this cycle may itself become the new head.
  assign w_bypass = w_push &&
                    (w_rd_n[AW-1:0] == r_wr[AW-1:0]);
  assign w_head_n = w_bypass ? i_din
                             : r_mem[w_rd_n[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push && !rst)
      r_mem[r_wr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_wr    <= w_wr_n;
      r_rd    <= w_rd_n;
      r_valid <= (w_wr_n != w_rd_n);
      if (w_wr_n != w_rd_n)
        r_dout <= w_head_n;
    end
  end

  assign o_dout  = r_dout;
  assign o_valid = r_valid;

endmodule

// File: rtl/sar_result_fifo.sv
// Captures finished SAR words on creset rising edge into a result FIFO.
// Optional 4-sample averaging before the FIFO: define SAR_AVG4_EN.
module sar_result_fifo
  import sar_pkg::*;
#(
  parameter int ADC_BITS = SAR_ADC_BITS,
  parameter int DEPTH    = SAR_DEPTH,
  parameter int CNT_BITS = SAR_CNT_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADC_BITS-1:0] clc_in,
  input  logic                creset_in,
  output logic [ADC_BITS-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                overflow,
  input  logic                clr_ovf,
  output logic [CNT_BITS-1:0] conv_count
);

  logic                r_creset_d;
  logic                r_overflow;
  logic [CNT_BITS-1:0] r_conv_count;

  logic                w_cap;
  logic                w_req;
  logic [ADC_BITS-1:0] w_word;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;

  assign w_cap = creset_in & ~r_creset_d;

`ifdef SAR_AVG4_EN
  localparam int SW = ADC_BITS + 2;

  logic [SW-1:0] r_acc;
  logic [1:0]    r_phase;
  logic [SW-1:0] w_sum;

  assign w_sum  = r_acc + SW'(clc_in);
  assign w_req  = w_cap & (r_phase == 2'd3);
  assign w_word = w_sum[SW-1:2];

  // Accumulator clears on the 4th capture whether or not it is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_phase <= '0;
    end else if (w_cap) begin
      r_phase <= r_phase + 2'd1;
      r_acc   <= w_req ? '0 : w_sum;
    end
  end
`else
  assign w_req  = w_cap;
  assign w_word = clc_in;
`endif

  assign w_pop  = dout_valid & dout_ready & ~w_empty;
  assign w_push = w_req & (~w_full | w_pop);
  assign w_drop = w_req & w_full & ~w_pop;

  sar_sync_fifo #(
    .W     (ADC_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_word),
    .i_pop   (w_pop),
    .o_dout  (dout),
    .o_valid (dout_valid),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Edge register resets high so a level held through reset is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_creset_d   <= 1'b1;
      r_overflow   <= 1'b0;
      r_conv_count <= '0;
    end else begin
      r_creset_d <= creset_in;
      if (w_drop)
        r_overflow <= 1'b1;
      else if (clr_ovf)
        r_overflow <= 1'b0;
      if (w_push)
        r_conv_count <= r_conv_count + CNT_BITS'(1);
    end
  end

  assign overflow   = r_overflow;
  assign conv_count = r_conv_count;

endmodule

// File: tb/tb_sar_result_fifo.sv
// Scoreboard bench for sar_result_fifo with a queue-based reference model.
// Build with +define+SAR_AVG4_EN to exercise the averaging path.
module tb_sar_result_fifo;

  localparam int DEPTH = 4;
`ifdef SAR_AVG4_EN
  localparam int NCAP = 4;
`else
  localparam int NCAP = 1;
`endif

  logic        clk;
  logic        rst;
  logic [9:0]  clc_in;
  logic        creset_in;
  logic [9:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        overflow;
  logic        clr_ovf;
  logic [15:0] conv_count;

  sar_result_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .clc_in     (clc_in),
    .creset_in  (creset_in),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .conv_count (conv_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: occupancy count, scoreboard of accepted words.
  logic [9:0] sb[$];
  int         occ = 0;
  bit         m_prev = 1'b1;
  int         m_cnt = 0;
  bit         m_ovf = 1'b0;
  int         m_acc = 0;
  int         m_ph = 0;

  always @(posedge clk) begin
    bit         cap, popm, req, wasfull;
    logic [9:0] word;
    if (rst) begin
      occ = 0;
      sb.delete();
      m_prev = 1'b1;
      m_cnt = 0;
      m_ovf = 1'b0;
      m_acc = 0;
      m_ph = 0;
    end else begin
      cap = creset_in && !m_prev;
      m_prev = creset_in;
      popm = (occ > 0) && dout_ready;
      wasfull = (occ == DEPTH);
      req = 1'b0;
      word = '0;
      if (cap) begin
`ifdef SAR_AVG4_EN
        m_acc += int'(clc_in);
        m_ph++;
        if (m_ph == 4) begin
          req = 1'b1;
          word = 10'(m_acc / 4);
          m_acc = 0;
          m_ph = 0;
        end
`else
        req = 1'b1;
        word = clc_in;
`endif
      end
      if (popm) occ--;
      if (req && (!wasfull || popm)) begin
        occ++;
        sb.push_back(word);
        m_cnt = (m_cnt + 1) % 65536;
      end
      if (req && wasfull && !popm) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  // Monitor: compares every transfer and the status outputs.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid", 32'(dout_valid), 32'(occ > 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("conv_count", 32'(conv_count), m_cnt);
      if (dout_valid === 1'b1 && dout_ready === 1'b1 && rst === 1'b0) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL data actual=%0h required=none", dout);
        end else begin
          chk("data", 32'(dout), 32'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_hi(input logic [9:0] w, input bit clr);
    creset_in = 1'b1;
    clc_in = w;
    clr_ovf = clr;
    tick();
    creset_in = 1'b0;
    clr_ovf = 1'b0;
  endtask

  task automatic push_word(input logic [9:0] w, input bit clr);
    for (int i = 0; i < NCAP; i++) begin
      tick();
      pulse_hi(w, (i == NCAP - 1) ? clr : 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    dout_ready = 1'b1;
    for (int i = 0; i < 40 && dout_valid; i++) tick();
    chk("drained", 32'(dout_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    creset_in = 1'b1;
    clc_in = '0;
    dout_ready = 1'b0;
    clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_cnt", 32'(conv_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    creset_in = 1'b0;
    tick();

    dout_ready = 1'b1;
    push_word(10'h2A5, 1'b0);
    chk("t2_valid", 32'(dout_valid), 32'd1);
    chk("t2_dout", 32'(dout), 32'h2A5);
    chk("t2_cnt", 32'(conv_count), 32'd1);
    tick();
    chk("t2_valid_after", 32'(dout_valid), 32'd0);

    do_reset();
    dout_ready = 1'b0;
    for (int k = 1; k <= 5; k++) push_word(10'(k), 1'b0);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_cnt", 32'(conv_count), 32'd4);
    chk("t3_head", 32'(dout), 32'h001);
    push_word(10'h006, 1'b1);
    chk("t3_clr_vs_drop", 32'(overflow), 32'd1);
    tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_clr", 32'(overflow), 32'd0);
    drain();
    chk("t3_cnt_end", 32'(conv_count), 32'd4);

    do_reset();
    dout_ready = 1'b0;
    push_word(10'h010, 1'b0);
    push_word(10'h020, 1'b0);
    push_word(10'h030, 1'b0);
    push_word(10'h040, 1'b0);
    for (int i = 0; i < NCAP - 1; i++) begin
      tick();
      pulse_hi(10'h3FF, 1'b0);
    end
    tick();
    dout_ready = 1'b1;
    creset_in = 1'b1;
    clc_in = 10'h3FF;
    tick();
    creset_in = 1'b0;
    chk("t4_ovf", 32'(overflow), 32'd0);
    chk("t4_cnt", 32'(conv_count), 32'd5);
    chk("t4_head", 32'(dout), 32'h020);
    drain();

    force dut.r_conv_count = 16'hFFFF;
    m_cnt = 16'hFFFF;
    tick();
    release dut.r_conv_count;
    tick();
    chk("t5_pre", 32'(conv_count), 32'hFFFF);
    push_word(10'h155, 1'b0);
    chk("t5_wrap", 32'(conv_count), 32'd0);
    drain();

`ifdef SAR_AVG4_EN
    do_reset();
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pulse_hi(10'h100 + 10'(i), 1'b0);
      chk("t6_valid", 32'(dout_valid), 32'(i == 3));
    end
    chk("t6_dout", 32'(dout), 32'h101);
    chk("t6_cnt", 32'(conv_count), 32'd1);
    drain();
`endif

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom % 150) == 0;
      creset_in = ($urandom % 3) == 0;
      clc_in = 10'($urandom);
      dout_ready = ($urandom % 4) != 0;
      clr_ovf = ($urandom % 40) == 0;
      tick();
    end
    rst = 1'b0;
    creset_in = 1'b0;
    clr_ovf = 1'b0;
    tick();
    drain();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
